// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared constants and byte-enable helpers for dmem_pipelined
package dmem_pkg;

  localparam int MAX_RD_LATENCY = 4;
  localparam int MAX_RSP_DEPTH  = MAX_RD_LATENCY + 1;
  localparam int MAX_BYTES      = 64;

  function automatic int rsp_depth(input int rd_latency);
    return rd_latency + 1;
  endfunction

  // Legal enables are one contiguous run, power-of-2 long, starting on a multiple of its length.
  function automatic bit be_aligned(input logic [MAX_BYTES-1:0] be, input int nbytes);
    int cnt;
    int first;
    logic [MAX_BYTES-1:0] run;
    cnt   = 0;
    first = 0;
    for (int i = MAX_BYTES - 1; i >= 0; i--) begin
      if (be[i]) begin
        cnt   = cnt + 1;
        first = i;
      end
    end
    run = ((MAX_BYTES'(1) << cnt) - MAX_BYTES'(1)) << first;
    if (cnt == 0 || cnt > nbytes) return 1'b0;
    return ((cnt & (cnt - 1)) == 0) && ((first % cnt) == 0) && (be == run);
  endfunction

endpackage

// File: rtl/dmem_rsp_fifo.sv
// rtl/dmem_rsp_fifo.sv - in-order response FIFO for dmem_pipelined
module dmem_rsp_fifo #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 33
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic [WIDTH-1:0] push_data,
  input  logic             pop,
  output logic [WIDTH-1:0] pop_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push;
  logic             do_pop;

  assign empty   = (count == '0);
  assign full    = (count == CNT_W'(DEPTH));
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;
  // Head reads as zero when empty so response outputs are clean out of reset.
  assign pop_data = empty ? '0 : mem[rd_ptr];

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + PTR_W'(1);
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/dmem_pipelined.sv
// rtl/dmem_pipelined.sv - byte-addressable data memory with read-latency pipeline and credit flow control
// Optional byte-enable alignment checking: DMEM_ALIGN_CHK_EN
module dmem_pipelined
  import dmem_pkg::*;
#(
  parameter int                DATA_W      = 32,
  parameter int                ADDR_W      = 32,
  parameter int                DEPTH_BYTES = 65536,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                RD_LATENCY  = 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                req_valid,
  output logic                req_ready,
  input  logic                req_we,
  input  logic [DATA_W/8-1:0] req_be,
  input  logic [ADDR_W-1:0]   req_addr,
  input  logic [DATA_W-1:0]   req_wdata,
  output logic                rsp_valid,
  input  logic                rsp_ready,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err
);

  localparam int BYTES     = DATA_W / 8;
  localparam int IDX_W     = $clog2(DEPTH_BYTES);
  localparam int RSP_DEPTH = rsp_depth(RD_LATENCY);
  localparam int STAGES    = RD_LATENCY - 1;
  localparam int CNT_W     = $clog2(RSP_DEPTH + 1);

  typedef struct packed {
    logic              err;
    logic [DATA_W-1:0] rdata;
  } dmem_rsp_t;

  logic [7:0]        mem [DEPTH_BYTES];
  logic [ADDR_W-1:0] offset;
  logic              in_range;
  logic              be_ok;
  logic              req_err;
  logic [IDX_W-1:0]  byte_base;
  logic [DATA_W-1:0] rd_word;
  logic              accept;
  logic              pop;
  logic [CNT_W-1:0]  outstanding;
  dmem_rsp_t         rsp_in;
  dmem_rsp_t         push_rsp;
  dmem_rsp_t         fifo_out;
  logic              push;
  logic              fifo_empty;
  logic              fifo_full;

  // Unsigned subtraction makes addresses below BASE_ADDR wrap high and fail the range test.
  assign offset    = req_addr - BASE_ADDR;
  assign in_range  = ((offset >> IDX_W) == '0);
  assign byte_base = offset[IDX_W-1:0] & ~IDX_W'(BYTES - 1);

`ifdef DMEM_ALIGN_CHK_EN
  assign be_ok = be_aligned(MAX_BYTES'(req_be), BYTES);
`else
  assign be_ok = 1'b1;
`endif

  assign req_err   = ~in_range | ~be_ok;
  assign req_ready = (outstanding < CNT_W'(RSP_DEPTH)) & ~fifo_full;
  assign accept    = req_valid & req_ready;
  assign pop       = rsp_valid & rsp_ready;

  always_comb begin
    rd_word = '0;
    for (int i = 0; i < BYTES; i++) begin
      rd_word[8*i +: 8] = mem[byte_base + IDX_W'(i)];
    end
  end

  assign rsp_in.err   = req_err;
  assign rsp_in.rdata = (req_we | req_err) ? '0 : rd_word;

  always_ff @(posedge clk) begin
    if (accept && req_we && !req_err) begin
      for (int i = 0; i < BYTES; i++) begin
        if (req_be[i]) mem[byte_base + IDX_W'(i)] <= req_wdata[8*i +: 8];
      end
    end
  end

  // The FIFO write is the final latency stage, so only RD_LATENCY-1 registers precede it.
  generate
    if (STAGES == 0) begin : g_direct
      assign push     = accept;
      assign push_rsp = rsp_in;
    end else begin : g_pipe
      logic [STAGES-1:0] stg_valid;
      dmem_rsp_t         stg_rsp [STAGES];

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          stg_valid <= '0;
          for (int s = 0; s < STAGES; s++) stg_rsp[s] <= '0;
        end else begin
          stg_valid[0] <= accept;
          stg_rsp[0]   <= rsp_in;
          for (int s = 1; s < STAGES; s++) begin
            stg_valid[s] <= stg_valid[s-1];
            stg_rsp[s]   <= stg_rsp[s-1];
          end
        end
      end

      assign push     = stg_valid[STAGES-1];
      assign push_rsp = stg_rsp[STAGES-1];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      outstanding <= '0;
    end else begin
      case ({accept, pop})
        2'b10:   outstanding <= outstanding + CNT_W'(1);
        2'b01:   outstanding <= outstanding - CNT_W'(1);
        default: outstanding <= outstanding;
      endcase
    end
  end

  dmem_rsp_fifo #(
    .DEPTH(RSP_DEPTH),
    .WIDTH($bits(dmem_rsp_t))
  ) u_rsp_fifo (
    .clk      (clk),
    .rst      (rst),
    .push     (push),
    .push_data(push_rsp),
    .pop      (pop),
    .pop_data (fifo_out),
    .empty    (fifo_empty),
    .full     (fifo_full)
  );

  assign rsp_valid = ~fifo_empty;
  assign rsp_rdata = fifo_out.rdata;
  assign rsp_err   = fifo_out.err;

endmodule

// File: tb/tb_dmem_pipelined.sv
// tb/tb_dmem_pipelined.sv - randomized self-checking bench for dmem_pipelined against a behavioural model
`timescale 1ns/1ps
module tb_dmem_pipelined;

  localparam int          DATA_W      = 32;
  localparam int          ADDR_W      = 32;
  localparam int          DEPTH_BYTES = 65536;
  localparam int          RD_LATENCY  = 2;
  localparam logic [31:0] BASE_ADDR   = 32'h0000_2000;
  localparam int          RSP_DEPTH   = RD_LATENCY + 1;
  localparam logic [31:0] WIN         = BASE_ADDR + 32'h100;
`ifdef DMEM_ALIGN_CHK_EN
  localparam bit ALIGN_CHK = 1'b1;
`else
  localparam bit ALIGN_CHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [3:0]  req_be = 4'h0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        rsp_valid;
  logic        rsp_ready = 1'b1;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  dmem_pipelined #(
    .DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH_BYTES(DEPTH_BYTES),
    .BASE_ADDR(BASE_ADDR), .RD_LATENCY(RD_LATENCY)
  ) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we), .req_be(req_be),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err)
  );

  always #5 clk = ~clk;

  int unsigned cyc = 0;
  always @(posedge clk) cyc++;

  int n_checks = 0;
  int n_fail   = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endfunction

  // Reference model: byte array plus the queue of accepted-but-unpopped responses.
  typedef struct {
    int unsigned acc;
    logic [31:0] rdata;
    logic        err;
  } exp_t;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
  } got_t;

  logic [7:0] mm [int unsigned];
  exp_t       eq[$];
  got_t       got[$];

  function automatic logic [31:0] mread(input int unsigned a);
    logic [31:0] v;
    v = '0;
    for (int b = 0; b < 4; b++) if (mm.exists(a + b)) v[8*b +: 8] = mm[a + b];
    return v;
  endfunction

  function automatic bit be_legal(input logic [3:0] be);
    return !ALIGN_CHK ||
           (be inside {4'b0001, 4'b0010, 4'b0100, 4'b1000, 4'b0011, 4'b1100, 4'b1111});
  endfunction

  always @(negedge clk) begin
    exp_t        e;
    got_t        g;
    int unsigned off;
    int unsigned wo;
    bit          due;
    if (rst) begin
      check("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      check("rst_req_ready", {31'b0, req_ready}, 32'd1);
      check("rst_rsp_err", {31'b0, rsp_err}, 32'd0);
      check("rst_rsp_rdata", rsp_rdata, 32'd0);
      eq.delete();
    end else begin
      due = (eq.size() > 0) && (cyc >= eq[0].acc + RD_LATENCY - 1);
      check("rsp_valid", {31'b0, rsp_valid}, {31'b0, due});
      check("req_ready", {31'b0, req_ready}, {31'b0, eq.size() < RSP_DEPTH});
      if (rsp_valid && eq.size() > 0) begin
        check("rsp_rdata", rsp_rdata, eq[0].rdata);
        check("rsp_err", {31'b0, rsp_err}, {31'b0, eq[0].err});
        if (rsp_ready) begin
          g.rdata = rsp_rdata;
          g.err   = rsp_err;
          got.push_back(g);
          void'(eq.pop_front());
        end
      end
      if (req_valid && req_ready) begin
        off     = req_addr - BASE_ADDR;
        wo      = off & ~32'd3;
        e.acc   = cyc + 1;
        e.err   = (off >= 32'(DEPTH_BYTES)) || !be_legal(req_be);
        e.rdata = '0;
        if (!e.err && !req_we) e.rdata = mread(wo);
        if (!e.err && req_we)
          for (int b = 0; b < 4; b++) if (req_be[b]) mm[wo + b] = req_wdata[8*b +: 8];
        eq.push_back(e);
      end
    end
  end

  task automatic send(input logic we, input logic [3:0] be, input logic [31:0] addr,
                      input logic [31:0] wdata);
    int t;
    req_we = we; req_be = be; req_addr = addr; req_wdata = wdata; req_valid = 1'b1;
    t = 0;
    @(negedge clk);
    while (!req_ready && t < 200) begin
      @(negedge clk);
      t++;
    end
    if (!req_ready) check("send_timeout", 32'd0, 32'd1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int t;
    t = 0;
    @(negedge clk);
    while (eq.size() != 0 && t < 300) begin
      @(negedge clk);
      t++;
    end
    check("drain_timeout", {31'b0, eq.size() == 0}, 32'd1);
    @(posedge clk); #1;
  endtask

  bit rand_on = 1'b0;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, failures so far %0d", n_fail);
    $fatal(1);
  end

  initial begin
    int unsigned acc_c;
    int          n;
    logic [31:0] held;
    logic [31:0] a;

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    for (int i = 0; i < 64; i++) send(1'b1, 4'hF, WIN + 32'(4 * i), $urandom);
    send(1'b1, 4'hF, BASE_ADDR + DEPTH_BYTES - 4, 32'h1234_5678);
    wait_idle();

    // Full-word write, then read with latency measurement.
    send(1'b1, 4'hF, WIN, 32'hDEAD_BEEF);
    wait_idle();
    send(1'b0, 4'hF, WIN, 32'h0);
    acc_c = cyc;
    do @(negedge clk); while (!rsp_valid && cyc < acc_c + 20);
    check("rd_latency", cyc - acc_c, 32'(RD_LATENCY - 1));
    wait_idle();
    check("t1_rdata", got[$].rdata, 32'hDEAD_BEEF);
    check("t1_err", {31'b0, got[$].err}, 32'd0);

    // Byte-lane write immediately followed by a read of the same word.
    send(1'b1, 4'b0001, WIN, 32'h0000_00AA);
    send(1'b0, 4'hF, WIN, 32'h0);
    wait_idle();
    check("t2_rdata", got[$].rdata, 32'hDEAD_BEAA);

    // Range errors above the top and below the base.
    send(1'b0, 4'hF, BASE_ADDR + DEPTH_BYTES, 32'h0);
    wait_idle();
    check("t3_hi_err", {31'b0, got[$].err}, 32'd1);
    check("t3_hi_rdata", got[$].rdata, 32'd0);
    send(1'b1, 4'hF, BASE_ADDR - 4, 32'hCAFE_F00D);
    send(1'b0, 4'hF, BASE_ADDR + DEPTH_BYTES - 4, 32'h0);
    wait_idle();
    check("t3_lo_err", {31'b0, got[$-1].err}, 32'd1);
    check("t3_top_word", got[$].rdata, 32'h1234_5678);

    // Backpressure: only RSP_DEPTH requests go in while responses are stalled.
    rsp_ready = 1'b0;
    req_we = 1'b0; req_be = 4'hF; req_addr = WIN + 32'd4; req_valid = 1'b1;
    n = 0;
    repeat (8) begin
      @(negedge clk);
      if (req_ready) n++;
      @(posedge clk); #1;
      req_addr = WIN + 32'(4 * (n + 1));
    end
    req_valid = 1'b0;
    @(negedge clk);
    check("bp_accepts", 32'(n), 32'(RSP_DEPTH));
    check("bp_ready_low", {31'b0, req_ready}, 32'd0);
    held = rsp_rdata;
    repeat (3) begin
      @(negedge clk);
      check("bp_hold", rsp_rdata, held);
    end
    @(posedge clk); #1;
    rsp_ready = 1'b1;
    wait_idle();

    // Throughput: 64 back-to-back reads must be accepted on 64 consecutive edges.
    acc_c = 0;
    for (int i = 0; i < 64; i++) begin
      send(1'b0, 4'hF, WIN + 32'(4 * i), 32'h0);
      if (i == 0) acc_c = cyc;
    end
    check("tput_cycles", cyc - acc_c, 32'd63);
    wait_idle();

    // Random traffic with random consumer stalls.
    rand_on = 1'b1;
    fork
      begin
        while (rand_on) begin
          @(posedge clk); #1;
          rsp_ready = 1'($urandom_range(0, 1));
        end
      end
    join_none
    for (int i = 0; i < 300; i++) begin
      case ($urandom_range(0, 9))
        8:       a = BASE_ADDR + DEPTH_BYTES + 32'(4 * $urandom_range(0, 15));
        9:       a = BASE_ADDR - 32'(4 * $urandom_range(1, 16));
        default: a = WIN + 32'(4 * $urandom_range(1, 63)) + 32'($urandom_range(0, 3));
      endcase
      send(1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), a, $urandom);
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end
    rand_on = 1'b0;
    @(posedge clk); #2;
    rsp_ready = 1'b1;
    wait_idle();

    // Reset with three responses in flight.
    rsp_ready = 1'b0;
    req_we = 1'b0; req_be = 4'hF; req_addr = WIN; req_valid = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check("t6_rsp_valid", {31'b0, rsp_valid}, 32'd0);
    check("t6_req_ready", {31'b0, req_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b0;
    rsp_ready = 1'b1;
    send(1'b0, 4'hF, WIN, 32'h0);
    wait_idle();
    check("t6_persist", got[$].rdata, 32'hDEAD_BEAA);

`ifdef DMEM_ALIGN_CHK_EN
    send(1'b1, 4'b0110, WIN, 32'hFFFF_FFFF);
    send(1'b0, 4'hF, WIN, 32'h0);
    wait_idle();
    check("align_err", {31'b0, got[$-1].err}, 32'd1);
    check("align_unchanged", got[$].rdata, 32'hDEAD_BEAA);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
